mux_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 8:1 single-bit mux (select inputs i, j, k; data inputs a..h; output l) among 8 requesters.
- Drives the mux select lines, waits a programmable settle time and samples the mux output.
- Returns the sampled bit with its channel index over a valid/ready handshake.
- Sits between the request sources and the combinational mux. It is the only driver of the mux select lines.

---
 rtl/mux_rr_sched_if.sv | 31 +++
 rtl/mux_rr_sched.sv | 127 ++++++++++++
 tb/tb_mux_rr_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_sched_if.sv
// ============================================================================
// Module   : mux_rr_sched_if
// Brief    : Request, mux and result handshake bundle for mux_rr_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mux_rr_sched_if;
    logic [7:0] req;
    logic       mux_l;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       out_bit;
    logic [2:0] out_chan;
    logic       out_ready;
    logic       busy;

    // master is the scheduler; slave is the requesters, mux and consumer
    modport master (
        input  req, mux_l, out_ready,
        output sel, grant, out_valid, out_bit, out_chan, busy
    );

    modport slave (
        output req, mux_l, out_ready,
        input  sel, grant, out_valid, out_bit, out_chan, busy
    );
endinterface

`default_nettype wire

// File: rtl/mux_rr_sched.sv
// ============================================================================
// Module   : mux_rr_sched
// Brief    : Round-robin owner of a shared 8:1 mux; settles select, samples l.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_rr_sched #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    mux_rr_sched_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               bit_q, bit_d;
    logic [2:0]         chan_q, chan_d;
    logic               busy_q, busy_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         w_pick;
    logic [2:0]         w_idx;

    // Walk downward so the channel closest above the pointer is assigned last and wins
    always_comb begin
        w_pick = ptr_q;
        w_idx  = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            w_idx = ptr_q + 3'(k);
            if (bus.req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        bit_d   = bit_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    sel_d   = w_pick;
                    chan_d  = w_pick;
                    grant_d = 8'b1 << w_pick;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                bit_d   = bus.mux_l;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    grant_d = '0;
                    ptr_d   = sel_q + 3'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            chan_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            chan_q  <= chan_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
    assign bus.out_bit   = bit_q;
    assign bus.out_chan  = chan_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
// ============================================================================
// Module   : tb_mux_rr_sched
// Brief    : Directed bench for mux_rr_sched with a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_sched;
    localparam int SETTLE = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mux_rr_sched_if bus ();

    mux_rr_sched #(.SETTLE(SETTLE), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an owner, cycles since grant, and a held result
    int m_ptr, m_owner, m_age, m_sel, m_pick;
    bit m_valid, m_bit;
    bit m_live = 1'b0;
    int cyc_n  = 0;

    always @(posedge clock) begin
        cyc_n++;
        m_live = 1'b1;
        if (reset) begin
            m_ptr = 0; m_owner = -1; m_age = 0; m_sel = 0; m_valid = 1'b0; m_bit = 1'b0;
        end else if (m_owner < 0) begin
            m_pick = -1;
            for (int k = 0; k < 8; k++)
                if (m_pick < 0 && bus.req[(m_ptr + k) % 8]) m_pick = (m_ptr + k) % 8;
            if (m_pick >= 0) begin
                m_owner = m_pick; m_sel = m_pick; m_age = 0;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_age++;
            if (m_age == SETTLE + 1) begin
                m_valid = 1'b1;
                m_bit   = bus.mux_l;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("grant",     32'(bus.grant),     (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            chk("sel",       32'(bus.sel),       32'(m_sel));
            chk("out_chan",  32'(bus.out_chan),  32'(m_sel));
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("out_bit",   32'(bus.out_bit),   32'(m_bit));
            chk("busy",      32'(bus.busy),      32'(m_owner >= 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (bus.busy !== 1'b0 && t < 60) begin step(1); t++; end
        chk(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (bus.out_valid !== 1'b1 && t < 60) begin step(1); t++; end
        chk(name, 32'(bus.out_valid), 32'd1);
    endtask

    int gidx[$];
    int gcyc[$];

    task automatic collect(input int n);
        logic [7:0] prev;
        prev = bus.grant;
        gidx.delete();
        gcyc.delete();
        for (int t = 0; t < 80 && gidx.size() < n; t++) begin
            step(1);
            if (bus.grant != 8'h00 && prev == 8'h00) begin
                gidx.push_back($clog2(bus.grant));
                gcyc.push_back(cyc_n);
            end
            if (bus.out_valid) chk("xfer chan vs sel", 32'(bus.out_chan), 32'(bus.sel));
            prev = bus.grant;
        end
        chk("grant count", 32'(gidx.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = 8'h00; bus.mux_l = 1'b0; bus.out_ready = 1'b1;
        step(2);
        reset = 1'b0;

        // Idle with no requests
        step(10);
        chk("idle grant", 32'(bus.grant), 32'h00);
        chk("idle busy",  32'(bus.busy),  32'd0);
        chk("idle valid", 32'(bus.out_valid), 32'd0);
        chk("idle sel",   32'(bus.sel),   32'd0);

        // Single request on channel 3; withdrawing it must not abort
        bus.req = 8'h08; bus.mux_l = 1'b1;
        step(1);
        chk("ch3 sel",   32'(bus.sel),   32'd3);
        chk("ch3 grant", 32'(bus.grant), 32'h08);
        bus.req = 8'h00;
        step(2);
        chk("ch3 early valid", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("ch3 valid", 32'(bus.out_valid), 32'd1);
        chk("ch3 bit",   32'(bus.out_bit),   32'd1);
        chk("ch3 chan",  32'(bus.out_chan),  32'd3);
        step(1);
        chk("ch3 release", 32'(bus.grant), 32'h00);
        bus.req = 8'h18; bus.mux_l = 1'b0;
        step(1);
        chk("ptr4 grant", 32'(bus.grant), 32'h10);
        bus.req = 8'h00;
        wait_idle("ptr4 idle");

        // All channels requesting from pointer 0
        reset = 1'b1; step(1); reset = 1'b0;
        bus.req = 8'hFF;
        collect(9);
        for (int i = 0; i < gidx.size(); i++) begin
            chk("rr order", 32'(gidx[i]), 32'(i % 8));
            if (i > 0) chk("rr spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd5);
        end
        bus.req = 8'h00;
        wait_idle("rr idle");

        // Backpressure on channel 1 with mux_l toggling during HOLD
        bus.req = 8'h02; bus.out_ready = 1'b0; bus.mux_l = 1'b0;
        step(1);
        bus.req = 8'h00;
        wait_valid("bp valid");
        for (int i = 0; i < 6; i++) begin
            bus.mux_l = ~bus.mux_l;
            step(1);
            chk("bp valid hold", 32'(bus.out_valid), 32'd1);
            chk("bp bit hold",   32'(bus.out_bit),   32'd0);
            chk("bp chan hold",  32'(bus.out_chan),  32'd1);
        end
        bus.out_ready = 1'b1;
        step(1);
        chk("bp accepted", 32'(bus.out_valid), 32'd0);
        bus.mux_l = 1'b0;

        // Move pointer to 7, then wrap with 8'h81
        bus.req = 8'h40;
        step(1);
        chk("ch6 grant", 32'(bus.grant), 32'h40);
        bus.req = 8'h00;
        wait_idle("ch6 idle");
        bus.req = 8'h81;
        collect(2);
        if (gidx.size() == 2) begin
            chk("wrap first",  32'(gidx[0]), 32'd7);
            chk("wrap second", 32'(gidx[1]), 32'd0);
        end
        bus.req = 8'h00;
        wait_idle("wrap idle");
        reset = 1'b1; step(1); reset = 1'b0;
        bus.req = 8'h81;
        step(1);
        chk("ptr0 grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        wait_idle("ptr0 idle");

        // Reset during SETTLE
        bus.req = 8'h01; bus.mux_l = 1'b1;
        step(2);
        chk("settle busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step(1);
        chk("rst settle grant", 32'(bus.grant), 32'h00);
        chk("rst settle busy",  32'(bus.busy),  32'd0);
        chk("rst settle sel",   32'(bus.sel),   32'd0);
        reset = 1'b0;
        step(1);
        chk("post rst grant", 32'(bus.grant), 32'h01);

        // Reset during HOLD drops the pending result
        bus.req = 8'h00; bus.out_ready = 1'b0;
        wait_valid("hold valid");
        reset = 1'b1;
        step(1);
        chk("rst hold valid", 32'(bus.out_valid), 32'd0);
        chk("rst hold bit",   32'(bus.out_bit),   32'd0);
        chk("rst hold chan",  32'(bus.out_chan),  32'd0);
        reset = 1'b0;
        bus.req = 8'h01; bus.out_ready = 1'b1;
        step(1);
        chk("post hold grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        wait_idle("final idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
